// File: rtl/core_pkg.sv
// Shared types and encodings for the 8-bit core control unit: FSM states,
// ALU operation codes, opcode values and instruction field positions.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        HALTED = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_NAND = 2'b10,
        ALU_OR   = 2'b11
    } alu_op_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // ORI is recognised on the low three bits only; bit 3 belongs to its immediate.
    localparam logic [2:0] OP_ORI   = 3'b111;
    localparam logic [1:0] ORI_REG  = 2'd1;

    localparam int RA_MSB = 7;
    localparam int RA_LSB = 6;
    localparam int RB_MSB = 5;
    localparam int RB_LSB = 4;
    localparam int OP_MSB = 3;
    localparam int OP_LSB = 0;

    function automatic logic is_ori_op(input logic [7:0] ins);
        return ins[2:0] == OP_ORI;
    endfunction

endpackage

// File: rtl/control_fsm_mem_timeout_ctr.sv
// Memory wait watchdog: counts consecutive cycles a request is held without
// mem_ready and flags the cycle in which the count reaches LIMIT.
module mem_timeout_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Any cycle without an outstanding stalled request returns the count to zero,
    // so every new request starts from a clean count.
    always_comb begin
        count_next = '0;
        if (active && !ready) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = active && !ready && (count_next == W'(LIMIT));

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the 8-bit core. Build option CTRL_ILLEGAL_TRAP_EN
// turns illegal opcodes into an error halt instead of a NOP.
module control_fsm
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       mdr_load,
    output logic       pc_inc,
    output logic       pc_branch,
    output logic [1:0] reg_a,
    output logic [1:0] reg_b,
    output logic [1:0] reg_w,
    output logic       rf_write,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic       alu_b_imm,
    output logic       flag_write,
    output logic       halted,
    output logic       err
);

    state_e state_reg, state_next;
    logic   err_reg, err_next;
    logic   idle_reg;
    logic   timeout_hit;

    logic       is_load, is_store, is_alu, is_ori, is_branch, is_halt, br_cond;
    alu_op_e    op_alu;
    logic [3:0] opcode;
    logic [1:0] sel_a;

    assign opcode = instr[OP_MSB:OP_LSB];
    assign sel_a  = is_ori ? ORI_REG : instr[RA_MSB:RA_LSB];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_alu    = 1'b0;
        is_ori    = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        br_cond   = 1'b0;
        op_alu    = ALU_ADD;
        if (is_ori_op(instr)) begin
            is_alu = 1'b1;
            is_ori = 1'b1;
            op_alu = ALU_OR;
        end else begin
            case (opcode)
                OP_LOAD:  is_load = 1'b1;
                OP_STORE: is_store = 1'b1;
                OP_ADD:   begin is_alu = 1'b1; op_alu = ALU_ADD;  end
                OP_SUB:   begin is_alu = 1'b1; op_alu = ALU_SUB;  end
                OP_NAND:  begin is_alu = 1'b1; op_alu = ALU_NAND; end
                OP_BZ:    begin is_branch = 1'b1; br_cond = flag_z;  end
                OP_BNZ:   begin is_branch = 1'b1; br_cond = !flag_z; end
                OP_BPZ:   begin is_branch = 1'b1; br_cond = !flag_n; end
                OP_HALT:  is_halt = 1'b1;
                default:  ;
            endcase
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            mem_timeout_ctr #(
                .LIMIT(MEM_TIMEOUT)
            ) u_timeout (
                .clk     (clk),
                .rst     (rst),
                .active  (mem_req),
                .ready   (mem_ready),
                .expired (timeout_hit)
            );
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // idle_reg marks the first cycle after reset, which issues no request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
            err_reg   <= 1'b0;
            idle_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            idle_reg  <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            FETCH: begin
                if (timeout_hit) begin
                    state_next = HALTED;
                    err_next   = 1'b1;
                end else if (mem_ready && !idle_reg) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    state_next = HALTED;
                end else if (is_branch) begin
                    state_next = BRANCH;
                end else if (is_load || is_store) begin
                    state_next = MEM;
                end else if (is_alu) begin
                    state_next = EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = HALTED;
                    err_next   = 1'b1;
`else
                    state_next = FETCH;
`endif
                end
            end
            MEM: begin
                if (timeout_hit) begin
                    state_next = HALTED;
                    err_next   = 1'b1;
                end else if (mem_ready) begin
                    state_next = is_load ? WB : FETCH;
                end
            end
            EXEC, WB, BRANCH: state_next = FETCH;
            HALTED:           state_next = HALTED;
            default:          state_next = FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        mdr_load   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        reg_a      = 2'd0;
        reg_b      = 2'd0;
        reg_w      = 2'd0;
        rf_write   = 1'b0;
        wb_sel     = 1'b0;
        alu_op     = ALU_ADD;
        alu_b_imm  = 1'b0;
        flag_write = 1'b0;
        halted     = 1'b0;
        err        = err_reg;
        if (state_reg != FETCH) begin
            reg_a = sel_a;
            reg_b = instr[RB_MSB:RB_LSB];
            reg_w = sel_a;
        end
        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                mdr_load = is_load && mem_ready;
            end
            EXEC: begin
                rf_write   = 1'b1;
                flag_write = 1'b1;
                alu_op     = op_alu;
                alu_b_imm  = is_ori;
            end
            WB: begin
                rf_write = 1'b1;
                wb_sel   = 1'b1;
            end
            BRANCH: pc_branch = br_cond;
            HALTED: halted = 1'b1;
            default: ;
        endcase
        // Datapath strobes must never coincide with a reset cycle.
        if (rst) begin
            ir_load    = 1'b0;
            mdr_load   = 1'b0;
            pc_inc     = 1'b0;
            pc_branch  = 1'b0;
            rf_write   = 1'b0;
            flag_write = 1'b0;
        end
        if (idle_reg) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            reg_a    = 2'd0;
            reg_b    = 2'd0;
            reg_w    = 2'd0;
            halted   = 1'b0;
            err      = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: expected output vectors are queued per cycle
// and compared against the default instance and a MEM_TIMEOUT=4 instance.
module tb_control_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       mdr_load;
        logic       pc_inc;
        logic       pc_branch;
        logic [1:0] reg_a;
        logic [1:0] reg_b;
        logic [1:0] reg_w;
        logic       rf_write;
        logic       wb_sel;
        logic [1:0] alu_op;
        logic       alu_b_imm;
        logic       flag_write;
        logic       halted;
        logic       err;
    } out_t;

    typedef struct {
        int    which;
        out_t  exp;
        string tag;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst, flag_z, flag_n, mem_ready, ready2;
    logic [7:0] instr, instr2;

    logic       d_mem_req, d_mem_we, d_addr_sel, d_ir_load, d_mdr_load, d_pc_inc, d_pc_branch;
    logic [1:0] d_reg_a, d_reg_b, d_reg_w, d_alu_op;
    logic       d_rf_write, d_wb_sel, d_alu_b_imm, d_flag_write, d_halted, d_err;
    logic       t_mem_req, t_mem_we, t_addr_sel, t_ir_load, t_mdr_load, t_pc_inc, t_pc_branch;
    logic [1:0] t_reg_a, t_reg_b, t_reg_w, t_alu_op;
    logic       t_rf_write, t_wb_sel, t_alu_b_imm, t_flag_write, t_halted, t_err;

    out_t dut_o, dut2_o;
    sb_entry_t sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_fsm u_dut (
        .clk(clk), .rst(rst), .instr(instr), .flag_z(flag_z), .flag_n(flag_n),
        .mem_ready(mem_ready), .mem_req(d_mem_req), .mem_we(d_mem_we), .addr_sel(d_addr_sel),
        .ir_load(d_ir_load), .mdr_load(d_mdr_load), .pc_inc(d_pc_inc), .pc_branch(d_pc_branch),
        .reg_a(d_reg_a), .reg_b(d_reg_b), .reg_w(d_reg_w), .rf_write(d_rf_write),
        .wb_sel(d_wb_sel), .alu_op(d_alu_op), .alu_b_imm(d_alu_b_imm),
        .flag_write(d_flag_write), .halted(d_halted), .err(d_err)
    );

    control_fsm #(.MEM_TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst), .instr(instr2), .flag_z(flag_z), .flag_n(flag_n),
        .mem_ready(ready2), .mem_req(t_mem_req), .mem_we(t_mem_we), .addr_sel(t_addr_sel),
        .ir_load(t_ir_load), .mdr_load(t_mdr_load), .pc_inc(t_pc_inc), .pc_branch(t_pc_branch),
        .reg_a(t_reg_a), .reg_b(t_reg_b), .reg_w(t_reg_w), .rf_write(t_rf_write),
        .wb_sel(t_wb_sel), .alu_op(t_alu_op), .alu_b_imm(t_alu_b_imm),
        .flag_write(t_flag_write), .halted(t_halted), .err(t_err)
    );

    assign dut_o  = {d_mem_req, d_mem_we, d_addr_sel, d_ir_load, d_mdr_load, d_pc_inc, d_pc_branch,
                     d_reg_a, d_reg_b, d_reg_w, d_rf_write, d_wb_sel, d_alu_op, d_alu_b_imm,
                     d_flag_write, d_halted, d_err};
    assign dut2_o = {t_mem_req, t_mem_we, t_addr_sel, t_ir_load, t_mdr_load, t_pc_inc, t_pc_branch,
                     t_reg_a, t_reg_b, t_reg_w, t_rf_write, t_wb_sel, t_alu_op, t_alu_b_imm,
                     t_flag_write, t_halted, t_err};

    function automatic out_t zero_o();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t fetch_o(input logic rdy);
        out_t o = '0;
        o.mem_req = 1'b1;
        o.ir_load = rdy;
        o.pc_inc  = rdy;
        return o;
    endfunction

    function automatic out_t sel_o(input logic [7:0] ins, input logic ori);
        out_t o = '0;
        o.reg_a = ori ? 2'd1 : ins[7:6];
        o.reg_b = ins[5:4];
        o.reg_w = o.reg_a;
        return o;
    endfunction

    function automatic out_t exec_o(input logic [7:0] ins, input logic ori, input logic [1:0] op);
        out_t o = sel_o(ins, ori);
        o.rf_write   = 1'b1;
        o.flag_write = 1'b1;
        o.alu_op     = op;
        o.alu_b_imm  = ori;
        return o;
    endfunction

    function automatic out_t mem_o(input logic [7:0] ins, input logic we, input logic mdr);
        out_t o = sel_o(ins, 1'b0);
        o.mem_req  = 1'b1;
        o.addr_sel = 1'b1;
        o.mem_we   = we;
        o.mdr_load = mdr;
        return o;
    endfunction

    function automatic out_t wb_o(input logic [7:0] ins);
        out_t o = sel_o(ins, 1'b0);
        o.rf_write = 1'b1;
        o.wb_sel   = 1'b1;
        return o;
    endfunction

    function automatic out_t br_o(input logic [7:0] ins, input logic taken);
        out_t o = sel_o(ins, 1'b0);
        o.pc_branch = taken;
        return o;
    endfunction

    function automatic out_t halt_o(input logic [7:0] ins, input logic e);
        out_t o = sel_o(ins, 1'b0);
        o.halted = 1'b1;
        o.err    = e;
        return o;
    endfunction

    task automatic pop_check();
        sb_entry_t s;
        out_t act;
        s = sb.pop_front();
        act = (s.which == 0) ? dut_o : dut2_o;
        checks++;
        assert (act === s.exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", s.tag, act, s.exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input int which, input logic [7:0] ins, input logic rdy,
                        input out_t e, input string tag);
        if (which == 0) begin
            instr = ins;
            mem_ready = rdy;
        end else begin
            instr2 = ins;
            ready2 = rdy;
        end
        sb.push_back('{which, e, tag});
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic alu3(input logic [7:0] ins, input logic ori, input logic [1:0] op, input string tag);
        step(0, ins, 1'b1, fetch_o(1'b1), {tag, "_fetch"});
        step(0, ins, 1'b1, sel_o(ins, ori), {tag, "_decode"});
        step(0, ins, 1'b1, exec_o(ins, ori, op), {tag, "_exec"});
    endtask

    task automatic br3(input logic [7:0] ins, input logic taken, input string tag);
        step(0, ins, 1'b1, fetch_o(1'b1), {tag, "_fetch"});
        step(0, ins, 1'b1, sel_o(ins, 1'b0), {tag, "_decode"});
        step(0, ins, 1'b1, br_o(ins, taken), {tag, "_branch"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; instr = 8'h00; instr2 = 8'h00;
        flag_z = 1'b0; flag_n = 1'b0; mem_ready = 1'b0; ready2 = 1'b0;
        @(posedge clk);
        #1;
        step(0, 8'h00, 1'b0, zero_o(), "reset_active");
        rst = 1'b0;
        step(0, 8'h00, 1'b0, zero_o(), "reset_idle");
        step(0, 8'h00, 1'b0, fetch_o(1'b0), "fetch_wait");

        alu3(8'h64, 1'b0, 2'b00, "add");
        alu3(8'h36, 1'b0, 2'b01, "sub");
        alu3(8'h98, 1'b0, 2'b10, "nand");

        // LOAD R3 <- mem[R0] with two wait states
        step(0, 8'hC0, 1'b1, fetch_o(1'b1), "load_fetch");
        step(0, 8'hC0, 1'b1, sel_o(8'hC0, 1'b0), "load_decode");
        step(0, 8'hC0, 1'b0, mem_o(8'hC0, 1'b0, 1'b0), "load_wait1");
        step(0, 8'hC0, 1'b0, mem_o(8'hC0, 1'b0, 1'b0), "load_wait2");
        step(0, 8'hC0, 1'b1, mem_o(8'hC0, 1'b0, 1'b1), "load_done");
        step(0, 8'hC0, 1'b1, wb_o(8'hC0), "load_wb");

        step(0, 8'h62, 1'b1, fetch_o(1'b1), "store_fetch");
        step(0, 8'h62, 1'b1, sel_o(8'h62, 1'b0), "store_decode");
        step(0, 8'h62, 1'b0, mem_o(8'h62, 1'b1, 1'b0), "store_wait");
        step(0, 8'h62, 1'b1, mem_o(8'h62, 1'b1, 1'b0), "store_done");

        flag_z = 1'b1;
        br3(8'hE5, 1'b1, "bz_taken");
        flag_z = 1'b0;
        br3(8'hE5, 1'b0, "bz_not");
        br3(8'hE9, 1'b1, "bnz_taken");
        flag_n = 1'b1;
        br3(8'hED, 1'b0, "bpz_not");
        flag_n = 1'b0;
        br3(8'hED, 1'b1, "bpz_taken");

        alu3(8'hAF, 1'b1, 2'b11, "ori");

        step(0, 8'h03, 1'b1, fetch_o(1'b1), "illegal_fetch");
        step(0, 8'h03, 1'b1, sel_o(8'h03, 1'b0), "illegal_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(0, 8'h03, 1'b1, halt_o(8'h03, 1'b1), "illegal_trap");
        rst = 1'b1;
        step(0, 8'h03, 1'b1, halt_o(8'h03, 1'b1), "illegal_rst");
`else
        step(0, 8'h03, 1'b0, fetch_o(1'b0), "illegal_nop");
        rst = 1'b1;
        step(0, 8'h03, 1'b0, fetch_o(1'b0), "illegal_rst");
`endif
        rst = 1'b0;
        step(0, 8'h03, 1'b0, zero_o(), "illegal_rst_idle");

        // Reset while a LOAD data request is outstanding
        step(0, 8'hC0, 1'b1, fetch_o(1'b1), "rmem_fetch");
        step(0, 8'hC0, 1'b1, sel_o(8'hC0, 1'b0), "rmem_decode");
        rst = 1'b1;
        step(0, 8'hC0, 1'b1, mem_o(8'hC0, 1'b0, 1'b0), "rst_mid_mem");
        rst = 1'b0;
        step(0, 8'hC0, 1'b1, zero_o(), "mem_req_dropped");

        step(0, 8'h01, 1'b1, fetch_o(1'b1), "halt_fetch");
        step(0, 8'h01, 1'b1, sel_o(8'h01, 1'b0), "halt_decode");
        step(0, 8'h01, 1'b1, halt_o(8'h01, 1'b0), "halted_1");
        step(0, 8'h01, 1'b1, halt_o(8'h01, 1'b0), "halted_2");
        rst = 1'b1;
        step(0, 8'h01, 1'b1, halt_o(8'h01, 1'b0), "halt_rst");
        rst = 1'b0;
        step(0, 8'h01, 1'b0, zero_o(), "halt_rst_idle");
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h01, 1'b0, fetch_o(1'b0), "refetch_wait");
        end

        // Timeout instance: stalled since the last reset, so already halted with err
        rst = 1'b1;
        step(1, 8'h00, 1'b0, halt_o(8'h00, 1'b1), "to_stalled_err");
        rst = 1'b0;
        step(1, 8'h00, 1'b0, zero_o(), "to_idle");
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h00, 1'b0, fetch_o(1'b0), "to_fetch_wait");
        end
        step(1, 8'h00, 1'b1, fetch_o(1'b1), "to_fetch_done");
        step(1, 8'h00, 1'b1, sel_o(8'h00, 1'b0), "to_decode");
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h00, 1'b0, mem_o(8'h00, 1'b0, 1'b0), "to_mem_wait");
        end
        step(1, 8'h00, 1'b0, halt_o(8'h00, 1'b1), "to_halt_err1");
        step(1, 8'h00, 1'b1, halt_o(8'h00, 1'b1), "to_halt_err2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multicycle control unit for the simple 8-bit processor core. Sequences fetch/decode/execute/writeback across the 4x8 register file, the ALU and the shared instruction/data memory port. Drives the register file read/write selects and RFWrite, the ALU controls and the memory request handshake. Sits in rtl/core beside the datapath, which holds PC, IR, MDR and the flag registers.

Parameters:
MEM_TIMEOUT, 0, if nonzero, max cycles to wait on mem_ready before halting with err=1; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
instr  in  8  current IR contents
flag_z  in  1  registered zero flag
flag_n  in  1  registered negative flag
mem_ready  in  1  memory completes the held request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier, valid with mem_req
addr_sel  out  1  0 = PC, 1 = dataB as memory address
ir_load  out  1  latch memory read data into IR
mdr_load  out  1  latch memory read data into MDR
pc_inc  out  1  PC <= PC+1
pc_branch  out  1  PC <= PC + sext(instr[7:4])
reg_a  out  2  register file read address A
reg_b  out  2  register file read address B
reg_w  out  2  register file write address
rf_write  out  1  register file write enable
wb_sel  out  1  0 = ALU result, 1 = MDR
alu_op  out  2  00 add, 01 sub, 10 nand, 11 or
alu_b_imm  out  1  ALU B operand = zext(instr[7:3])
flag_write  out  1  update Z/N from ALU result
halted  out  1  core stopped
err  out  1  timeout or illegal-opcode halt

Behaviour:
- Reset: state FETCH, all outputs 0, timeout counter 0. Reset mid-operation abandons any outstanding request. mem_req drops in the cycle after rst is sampled.
- Encoding: Ra = instr[7:6], Rb = instr[5:4]. Opcodes in instr[3:0]: 0000 LOAD Ra<-mem[Rb]; 0010 STORE mem[Rb]<-Ra; 0100 ADD; 0110 SUB; 1000 NAND (Ra<-Ra op Rb, flags updated); xx111 ORI R1<-R1|zext(instr[7:3]), flags updated; 0101 BZ, 1001 BNZ, 1101 BPZ (branch offset instr[7:4], 4-bit signed); 0001 HALT; everything else is illegal.
- reg_a = Ra, reg_b = Rb, except ORI, where reg_a = reg_w = 1. These are combinational from instr in all states except FETCH.
- FETCH: mem_req=1, addr_sel=0. On mem_ready, pulse ir_load and pc_inc for 1 cycle, then go to DECODE. Without mem_ready, stay in FETCH with outputs held.
- DECODE: 1 cycle, no side effects. HALT goes to HALTED. Branches go to BRANCH. LOAD/STORE go to MEM. ALU ops go to EXEC. Illegal opcodes follow the optional feature.
- BRANCH: 1 cycle. pc_branch=1 when the condition holds: BZ needs Z; BNZ needs !Z; BPZ needs !N. The offset is relative to the already-incremented PC. Then go to FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. On mem_ready: STORE goes to FETCH; LOAD pulses mdr_load and goes to WB.
- EXEC: ALU controls are valid for 1 cycle. rf_write=1, reg_w=Ra, wb_sel=0, flag_write=1. Then go to FETCH.
- WB (LOAD only): rf_write=1, reg_w=Ra, wb_sel=1. Then go to FETCH.
- Cycle counts with zero-wait memory (mem_ready high in the first request cycle): ALU/ORI 3, branch 3, STORE 3, LOAD 4.
- rf_write, ir_load, mdr_load, pc_inc, pc_branch and flag_write are single-cycle pulses and are never asserted together with rst.
- Timeout (MEM_TIMEOUT>0): a counter clears whenever a request starts and increments each cycle mem_ready is low. When it reaches MEM_TIMEOUT, go to HALTED with err=1 and mem_req=0.
- HALTED: halted=1. All pulses are 0. Leave only via rst.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode goes DECODE -> HALTED with err=1.
- Undefined: an illegal opcode executes as a NOP, DECODE -> FETCH, and err stays 0.

Decomposition:
- Package core_pkg: state_e enum (FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALTED), opcode localparams, alu_op_e, field slice constants.
- Sub-module mem_timeout_ctr: counter plus compare. Instantiated only when MEM_TIMEOUT>0 (generate).
- Decode stays combinational inside control_fsm.

Test Plan:
- ADD: instr=8'b01_10_0100, mem_ready tied 1 -> FETCH/DECODE/EXEC. In EXEC: reg_a=1, reg_b=2, reg_w=1, alu_op=00, rf_write=1, flag_write=1. Back to FETCH in cycle 4.
- LOAD with 2 wait states: instr=8'b11_00_0000, mem_ready low 2 cycles in MEM -> mem_req held 3 cycles with addr_sel=1, then mdr_load pulses. WB has rf_write=1, reg_w=3, wb_sel=1.
- Branches: BZ instr=8'b1110_0101 with flag_z=1 -> pc_branch=1 for 1 cycle. Same instr with flag_z=0 -> pc_branch=0. BPZ with flag_n=1 -> pc_branch=0.
- ORI: instr=8'b10101_111 -> reg_a=1, reg_w=1, alu_b_imm=1, alu_op=11, rf_write=1.
- HALT (8'h01) -> halted=1, no further mem_req. Then rst high for 1 cycle -> FETCH with all outputs 0. Also assert rst mid-MEM -> mem_req=0 in the next cycle.
- Illegal 8'h03: with CTRL_ILLEGAL_TRAP_EN -> halted=1, err=1. Without it -> returns to FETCH with err=0. With MEM_TIMEOUT=4 and mem_ready stuck low -> err=1 after 4 cycles.
